// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// The zero/neg flag wires exist only when CLA_PIPE_FLAGS_EN is defined.
interface cla_pipe_addsub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         of;
`ifdef CLA_PIPE_FLAGS_EN
    logic         zero;
    logic         neg;
`endif

    modport master (
        output in_valid, in1, in2, cin, sub, out_ready,
`ifdef CLA_PIPE_FLAGS_EN
        input  zero, neg,
`endif
        input  in_ready, out_valid, sum, cout, of
    );

    modport slave (
        input  in_valid, in1, in2, cin, sub, out_ready,
`ifdef CLA_PIPE_FLAGS_EN
        output zero, neg,
`endif
        output in_ready, out_valid, sum, cout, of
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Elastic pipelined carry-lookahead adder/subtractor built from 4-bit CLA slices.
// Define CLA_PIPE_FLAGS_EN to add registered zero/neg result flags.
module cla_pipe_addsub #(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int W      = N / STAGES;
    localparam int SLICES = W / 4;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;

        logic [N-1:LO]    a_src;
        logic [N-1:LO]    b_src;
        logic             c_src;
        logic             v_src;
        logic [W-1:0]     s_slice;
        logic             c_slice;
        logic [LO+W-1:0]  r_nxt;
        logic             adv;
        logic             v_q;
        logic [LO+W-1:0]  r_q;
        logic             c_q;

        // Stage 0 folds the subtract into the operand and carry; later stages take the skewed beat.
        if (k == 0) begin : g_src
            assign a_src = bus.in1;
            assign b_src = bus.sub ? ~bus.in2 : bus.in2;
            assign c_src = bus.sub | bus.cin;
            assign v_src = bus.in_valid;
            assign r_nxt = s_slice;
        end else begin : g_src
            assign a_src = g_stage[k-1].g_skew.a_q;
            assign b_src = g_stage[k-1].g_skew.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign r_nxt = {s_slice, g_stage[k-1].r_q};
        end

        if (k == STAGES - 1) begin : g_adv
            assign adv = ~v_q | bus.out_ready;
        end else begin : g_adv
            assign adv = ~v_q | g_stage[k+1].adv;
        end

        always_comb begin
            logic [4:0] part;
            part    = '0;
            s_slice = '0;
            c_slice = c_src;
            for (int j = 0; j < SLICES; j++) begin
                part               = cla4(a_src[LO + 4*j +: 4], b_src[LO + 4*j +: 4], c_slice);
                s_slice[4*j +: 4]  = part[3:0];
                c_slice            = part[4];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                r_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_src;
                if (v_src) begin
                    r_q <= r_nxt;
                    c_q <= c_slice;
                end
            end
        end

        // Operand bits still to be added ride along with the beat.
        if (k < STAGES - 1) begin : g_skew
            logic [N-1:LO+W] a_q;
            logic [N-1:LO+W] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_src) begin
                    a_q <= a_src[N-1:LO+W];
                    b_q <= b_src[N-1:LO+W];
                end
            end
        end

        if (k == STAGES - 1) begin : g_out
            logic of_q;
`ifdef CLA_PIPE_FLAGS_EN
            logic zero_q;
            logic neg_q;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    of_q <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
`endif
                end else if (adv && v_src) begin
                    of_q <= (a_src[N-1] == b_src[N-1]) & (r_nxt[N-1] != a_src[N-1]);
`ifdef CLA_PIPE_FLAGS_EN
                    zero_q <= (r_nxt == '0);
                    neg_q  <= r_nxt[N-1];
`endif
                end
            end

            assign bus.out_valid = v_q;
            assign bus.sum       = r_q;
            assign bus.cout      = c_q;
            assign bus.of        = of_q;
`ifdef CLA_PIPE_FLAGS_EN
            assign bus.zero      = zero_q;
            assign bus.neg       = neg_q;
`endif
        end
    end

    assign bus.in_ready = g_stage[0].adv;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub at N=32, STAGES=2.
module tb_cla_pipe_addsub;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        of;
        logic        zero;
        logic        neg;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    res_t q[$];

    cla_pipe_addsub_if #(.N(32)) bus ();
    cla_pipe_addsub #(.N(32), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        logic [31:0] be;
        logic [32:0] t;
        res_t r;
        be     = s ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {32'd0, (s ? 1'b1 : c)};
        r      = '0;
        r.sum  = t[31:0];
        r.cout = t[32];
        r.of   = (a[31] == be[31]) && (t[31] != a[31]);
`ifdef CLA_PIPE_FLAGS_EN
        r.zero = (t[31:0] == 32'd0);
        r.neg  = t[31];
`endif
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One clock of stimulus; reports handshakes and the visible result, queues accepted beats.
    task automatic drive_cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic s, input logic ordy,
                               output logic acc, output logic ofire, output res_t got);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in1       = a;
        bus.in2       = b;
        bus.cin       = c;
        bus.sub       = s;
        bus.out_ready = ordy;
        #1;
        acc      = iv && bus.in_ready;
        ofire    = bus.out_valid && ordy;
        got      = '0;
        got.sum  = bus.sum;
        got.cout = bus.cout;
        got.of   = bus.of;
`ifdef CLA_PIPE_FLAGS_EN
        got.zero = bus.zero;
        got.neg  = bus.neg;
`endif
        if (acc) q.push_back(model(a, b, c, s));
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.sum !== 32'd0) begin errors++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
        checks++; if (bus.of !== 1'b0) begin errors++; $display("FAIL reset_of: got %b want 0", bus.of); end
`ifdef CLA_PIPE_FLAGS_EN
        checks++; if ({bus.zero, bus.neg} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b%b want 00", bus.zero, bus.neg); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_latency();
        logic acc, ofire;
        res_t got, exp, last;
        int   lat;
        drive_cycle(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, acc, ofire, got);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL lat_accept: got %b want 1", acc); end
        lat  = 0;
        last = '0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ofire, got);
            if (ofire) begin
                lat  = i;
                last = got;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL lat_extra: got sum=%h with empty queue", got.sum); end
                else begin
                    exp = q.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL lat_result: got %h want %h", got, exp); end
                end
            end
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL latency: got %0d want 2 cycles (0 = timeout)", lat); end
        checks++; if (last.sum !== 32'h0000_0000) begin errors++; $display("FAIL wrap_sum: got %h want 00000000", last.sum); end
        checks++; if (last.cout !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b want 1", last.cout); end
        checks++; if (last.of !== 1'b0) begin errors++; $display("FAIL wrap_of: got %b want 0", last.of); end
        q.delete();
    endtask

    task automatic test_vectors();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        logic acc, ofire;
        res_t got, exp;
        int   d;
        va = '{32'h8000_0000, 32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'd0, 32'd10};
        vb = '{32'h0000_0001, 32'd5, 32'h0000_0001, 32'h0000_0001, 32'd0, 32'd5, 32'd1, 32'd3};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        d  = 0;
        for (int c = 0; c < 120; c++) begin
            if (d < 8) begin
                drive_cycle(1'b1, va[d], vb[d], vc[d], vs[d], 1'b1, acc, ofire, got);
                if (acc) d++;
            end else if (c < 80) begin
                drive_cycle(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), acc, ofire, got);
            end else begin
                if (q.size() == 0) break;
                drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ofire, got);
            end
            if (ofire) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL vec_extra: got sum=%h with empty queue", got.sum); end
                else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL vec_result: got sum=%h c=%b of=%b z=%b n=%b want sum=%h c=%b of=%b z=%b n=%b",
                                 got.sum, got.cout, got.of, got.zero, got.neg, exp.sum, exp.cout, exp.of, exp.zero, exp.neg);
                    end
                end
            end
        end
        checks++; if (q.size() != 0 || d != 8) begin errors++; $display("FAIL vec_drain: got %0d pending, %0d sent want 0 pending, 8 sent", q.size(), d); end
        q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        logic acc, ofire, first_acc;
        res_t got, exp;
        int   idx, nouts, gaps;
        ba = '{32'h1111_1111, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFF0};
        bb = '{32'h2222_2222, 32'h0000_0001, 32'h0000_0005, 32'h0000_0010};
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, ba[idx], bb[idx], 1'b0, idx[0], 1'b0, acc, ofire, got);
            if (acc) idx++;
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepts: got %0d want 2", idx); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (q.size() == 0 || got !== q[0]) begin errors++; $display("FAIL stall_hold: got sum=%h want first beat result", got.sum); end
        nouts     = 0;
        gaps      = 0;
        first_acc = 1'b0;
        for (int c = 0; c < 12 && (q.size() > 0 || idx < 4); c++) begin
            drive_cycle(idx < 4, ba[idx % 4], bb[idx % 4], 1'b0, idx[0], 1'b1, acc, ofire, got);
            if (c == 0) first_acc = acc;
            if (acc) idx++;
            if (ofire) begin
                nouts++;
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL b2b_extra: got sum=%h with empty queue", got.sum); end
                else begin
                    exp = q.pop_front();
                    if (got !== exp) begin errors++; $display("FAIL b2b_result: got %h want %h", got, exp); end
                end
            end else if (nouts > 0 && nouts < 4) begin
                gaps++;
            end
        end
        checks++; if (first_acc !== 1'b1) begin errors++; $display("FAIL b2b_full_accept: got %b want 1", first_acc); end
        checks++; if (nouts != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", nouts); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
        q.delete();
    endtask

    task automatic test_reset_midflight();
        logic acc, ofire;
        res_t got;
        int   accepted, stale;
        accepted = 0;
        drive_cycle(1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 1'b0, acc, ofire, got);
        if (acc) accepted++;
        drive_cycle(1'b1, 32'd100, 32'd1, 1'b0, 1'b1, 1'b0, acc, ofire, got);
        if (acc) accepted++;
        drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc, ofire, got);
        checks++; if (accepted != 2 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d accepted valid=%b want 2 and 1", accepted, bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, ofire, got);
            if (ofire) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d results want 0", stale); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
